multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
Parametrised multicycle controller for the LEGv8 core. It replaces the single-cycle combinational decode with a Moore FSM that sequences fetch, decode, execute, memory and write-back. It handshakes with a variable-latency unified memory through mem_ready, guards each memory wait with a watchdog, and optionally decodes ADDI/SUBI and CBNZ. It sits between the instruction register and the multicycle datapath; the datapath latches the old PC on ir_write for branch-target generation.

Parameters:
OPCODE_W, 11, width of opcode field (IR[31:21])
MAX_WAIT, 15, maximum mem_ready=0 cycles tolerated per memory state; 0 disables the watchdog
SUPPORT_IMM, 1, 1 decodes ADDI/SUBI; 0 treats them as illegal
SUPPORT_CBNZ, 1, 1 decodes CBNZ; 0 treats it as illegal

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
opcode  in  OPCODE_W  IR[31:21], stable from DECODE until return to FETCH
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  PC load enable
pc_src  out  2  00 PC+4, 01 conditional target, 10 unconditional target
ir_write  out  1  IR load enable (datapath also latches old PC)
iord  out  1  memory address: 0 PC, 1 ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg2loc  out  1  read-reg2 from Rt (IR[4:0]) when 1
alu_src_b  out  2  00 register, 01 sign-extended immediate
alu_op  out  2  00 add, 01 pass-B, 10 R-type funct, 11 immediate add/sub
mem_to_reg  out  1  write-back from memory data
reg_write  out  1  register file write enable
instr_done  out  1  one-cycle pulse on the final cycle of each instruction
illegal_instr  out  1  one-cycle pulse in DECODE on an unsupported opcode
fault  out  1  sticky; set in FAULT until reset
state_o  out  4  current state encoding, for debug

Behaviour:
- Reset: state goes to FETCH and the wait counter clears. While reset=1, every output is forced to 0.
- Outputs are Moore, decoded from state. reg2loc and the zero/opcode-qualified outputs are the only exceptions.
- reg2loc is 1 for STUR, CBZ and CBNZ, decoded from opcode, in every state except FETCH.
- Any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0.
  - If mem_ready: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
- DECODE: classify opcode.
  - ADD/SUB/AND/ORR go to EXEC_R.
  - ADDI/SUBI (1001000100x / 1101000100x) go to EXEC_I.
  - LDUR/STUR go to ADDR.
  - CBZ (10110100xxx), CBNZ (10110101xxx) and B (000101xxxxx) go to BRANCH.
  - Anything else: illegal_instr=1, go to FAULT.
- EXEC_R: alu_src_b=00, alu_op=10, then WB_ALU.
- EXEC_I: alu_src_b=01, alu_op=11, then WB_ALU.
- ADDR: alu_src_b=01, alu_op=00, then MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD: mem_read=1, iord=1. Hold until mem_ready, then WB_MEM.
- MEM_WR: mem_write=1, iord=1. Hold until mem_ready, then instr_done=1 and go to FETCH.
- WB_ALU: reg_write=1, mem_to_reg=0, instr_done=1, then FETCH.
- WB_MEM: reg_write=1, mem_to_reg=1, instr_done=1, then FETCH.
- BRANCH: alu_src_b=00, alu_op=01, instr_done=1, then FETCH.
  - B: pc_write=1, pc_src=10.
  - CBZ: pc_write=zero, pc_src=01.
  - CBNZ: pc_write=~zero, pc_src=01.
- FAULT: only fault=1. Absorbing; exits only via reset.
- Watchdog:
  - Counter width $clog2(MAX_WAIT+1). It clears on entry to FETCH, MEM_RD and MEM_WR.
  - It increments on each cycle in those states with mem_ready=0.
  - If cnt==MAX_WAIT and mem_ready=0, next state is FAULT.
  - mem_ready=1 on the limit cycle wins; no fault.
- Latency with zero-wait memory: R/I-type 4 cycles, LDUR 5, STUR 4, branches 3. Each memory wait cycle adds 1.
- mem_read and mem_write are never both 1.
- Reset asserted mid-instruction takes priority over every transition. There is no partial write-back.

Decomposition:
- Package legv8_ctrl_pkg holds:
  - the state enum: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, FAULT;
  - opcode match constants and masks;
  - alu_op and pc_src encodings.
- INSTR_LEN stays in constants.vh.
- One combinational sub-module, legv8_opcode_class, maps opcode plus the SUPPORT_* parameters to an instruction class and reg2loc.

Test Plan:
- ADD 0x8B09026A, mem_ready=1 → states FETCH, DECODE, EXEC_R, WB_ALU; alu_op=10 in cycle 3; reg_write=1 and instr_done=1 in cycle 4 only.
- LDUR 0xF84402C9, mem_ready low 3 cycles in MEM_RD → mem_read=iord=1 for 4 cycles, then WB_MEM with mem_to_reg=1, reg_write=1; 8 cycles total.
- Branches:
  - CBZ 0xB4FFFF6B with zero=1 → pc_write=1, pc_src=01; with zero=0 → pc_write=0.
  - CBNZ 0xB5FFFF6B → the inverse of CBZ.
  - B 0x14000040 → pc_write=1, pc_src=10; reg2loc=0.
- Watchdog (MAX_WAIT=4, mem_ready=0 in FETCH) → FAULT on the 6th cycle; fault stays 1 after mem_ready=1; a reset pulse returns to FETCH with fault=0.
- Illegal and immediate decode:
  - 0x00000000 → illegal_instr pulse in DECODE, then FAULT.
  - ADDI 0x91000529 with SUPPORT_IMM=0 → FAULT.
  - ADDI 0x91000529 with SUPPORT_IMM=1 → EXEC_I with alu_src_b=01, alu_op=11.
- STUR 0xF80602CB, reset asserted during MEM_WR → mem_write=0 in the reset cycle; FETCH with mem_read=1 on the first cycle after deassert; no instr_done.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
// Shared types and constants for the LEGv8 multicycle controller:
// state encoding, instruction classes, opcode patterns and control encodings.
package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    MEM_WR = 4'd6,
    WB_ALU = 4'd7,
    WB_MEM = 4'd8,
    BRANCH = 4'd9,
    FAULT  = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_LD   = 3'd2,
    CLS_ST   = 3'd3,
    CLS_CBZ  = 3'd4,
    CLS_CBNZ = 3'd5,
    CLS_B    = 3'd6,
    CLS_ILL  = 3'd7
  } instr_class_t;

  localparam int OPC_BITS = 11;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_ADDI = 11'b10010001000;
  localparam logic [10:0] OPC_SUBI = 11'b11010001000;
  localparam logic [10:0] MASK_IMM = 11'b11111111110;
  localparam logic [10:0] OPC_CBZ  = 11'b10110100000;
  localparam logic [10:0] OPC_CBNZ = 11'b10110101000;
  localparam logic [10:0] MASK_CB  = 11'b11111111000;
  localparam logic [10:0] OPC_B    = 11'b00010100000;
  localparam logic [10:0] MASK_B   = 11'b11111100000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_PASSB = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  localparam logic [1:0] ALUB_REG = 2'b00;
  localparam logic [1:0] ALUB_IMM = 2'b01;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_COND   = 2'b01;
  localparam logic [1:0] PC_SRC_UNCOND = 2'b10;

  // Pure Moore control word; input-qualified outputs are formed in the top.
  typedef struct packed {
    logic       mem_read;
    logic       iord;
    logic       mem_write;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       fault;
  } ctrl_t;

  function automatic logic op_match(logic [10:0] op, logic [10:0] val, logic [10:0] mask);
    return (op & mask) == val;
  endfunction

  function automatic ctrl_t moore_ctrl(state_t s);
    ctrl_t c;
    c = {$bits(ctrl_t){1'b0}};
    case (s)
      FETCH:  c.mem_read = 1'b1;
      EXEC_R: begin c.alu_src_b = ALUB_REG; c.alu_op = ALU_RTYPE; end
      EXEC_I: begin c.alu_src_b = ALUB_IMM; c.alu_op = ALU_IMM; end
      ADDR:   begin c.alu_src_b = ALUB_IMM; c.alu_op = ALU_ADD; end
      MEM_RD: begin c.mem_read = 1'b1; c.iord = 1'b1; end
      MEM_WR: begin c.mem_write = 1'b1; c.iord = 1'b1; end
      WB_ALU: begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
      WB_MEM: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; end
      BRANCH: begin c.alu_src_b = ALUB_REG; c.alu_op = ALU_PASSB; c.instr_done = 1'b1; end
      FAULT:  c.fault = 1'b1;
      default: c = {$bits(ctrl_t){1'b0}};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle. The controller uses the slave modport,
// the datapath side (or a testbench) the master modport.
interface multicycle_control_if #(parameter int OPCODE_W = 11);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;
  logic                pc_write;
  logic [1:0]          pc_src;
  logic                ir_write;
  logic                iord;
  logic                mem_read;
  logic                mem_write;
  logic                reg2loc;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic                mem_to_reg;
  logic                reg_write;
  logic                instr_done;
  logic                illegal_instr;
  logic                fault;
  logic [3:0]          state_o;

  modport slave (
    input  opcode, zero, mem_ready,
    output pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg2loc,
           alu_src_b, alu_op, mem_to_reg, reg_write, instr_done,
           illegal_instr, fault, state_o
  );

  modport master (
    output opcode, zero, mem_ready,
    input  pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg2loc,
           alu_src_b, alu_op, mem_to_reg, reg_write, instr_done,
           illegal_instr, fault, state_o
  );
endinterface

// File: rtl/legv8_opcode_class.sv
// Combinational opcode classifier; optional instructions fold into CLS_ILL
// when their SUPPORT_* parameter is 0.
module legv8_opcode_class
  import legv8_ctrl_pkg::*;
#(
  parameter int SUPPORT_IMM  = 1,
  parameter int SUPPORT_CBNZ = 1
) (
  input  logic [10:0]  opcode,
  output instr_class_t cls,
  output logic         reg2loc
);

  // Map opcode to class; reg2loc follows the class so a disabled CBNZ reads Rm.
  always_comb begin
    cls = CLS_ILL;
    if (opcode == OPC_ADD || opcode == OPC_SUB || opcode == OPC_AND || opcode == OPC_ORR) begin
      cls = CLS_R;
    end else if ((SUPPORT_IMM != 0) &&
                 (op_match(opcode, OPC_ADDI, MASK_IMM) || op_match(opcode, OPC_SUBI, MASK_IMM))) begin
      cls = CLS_I;
    end else if (opcode == OPC_LDUR) begin
      cls = CLS_LD;
    end else if (opcode == OPC_STUR) begin
      cls = CLS_ST;
    end else if (op_match(opcode, OPC_CBZ, MASK_CB)) begin
      cls = CLS_CBZ;
    end else if ((SUPPORT_CBNZ != 0) && op_match(opcode, OPC_CBNZ, MASK_CB)) begin
      cls = CLS_CBNZ;
    end else if (op_match(opcode, OPC_B, MASK_B)) begin
      cls = CLS_B;
    end else begin
      cls = CLS_ILL;
    end
    reg2loc = (cls == CLS_ST) || (cls == CLS_CBZ) || (cls == CLS_CBNZ);
  end

endmodule

// File: rtl/multicycle_control.sv
// LEGv8 multicycle controller: Moore FSM with a per-memory-state watchdog.
// Control word is registered from the next state; only input-qualified bits are combinational.
module multicycle_control
  import legv8_ctrl_pkg::*;
#(
  parameter int OPCODE_W     = 11,
  parameter int MAX_WAIT     = 15,
  parameter int SUPPORT_IMM  = 1,
  parameter int SUPPORT_CBNZ = 1
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.slave bus
);

  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

  state_t           state_r;
  state_t           next_state_s;
  ctrl_t            ctl_r;
  logic [CNT_W-1:0] wait_cnt_r;
  instr_class_t     cls_s;
  logic             r2l_s;
  logic [10:0]      opc_s;
  logic             waiting_s;
  logic             wd_hit_s;
  logic             pc_write_s;
  logic [1:0]       pc_src_s;
  logic             ir_write_s;
  logic             instr_done_s;
  logic             illegal_s;

  assign opc_s = bus.opcode[OPCODE_W-1 -: OPC_BITS];

  legv8_opcode_class #(
    .SUPPORT_IMM  (SUPPORT_IMM),
    .SUPPORT_CBNZ (SUPPORT_CBNZ)
  ) u_class (
    .opcode  (opc_s),
    .cls     (cls_s),
    .reg2loc (r2l_s)
  );

  assign waiting_s = ((state_r == FETCH) || (state_r == MEM_RD) || (state_r == MEM_WR)) && !bus.mem_ready;
  // A ready on the limit cycle still completes the access.
  assign wd_hit_s  = (MAX_WAIT != 0) && waiting_s && (wait_cnt_r == WAIT_LIM);

  // Next-state selection.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      FETCH: begin
        if (bus.mem_ready)  next_state_s = DECODE;
        else if (wd_hit_s)  next_state_s = FAULT;
        else                next_state_s = FETCH;
      end
      DECODE: begin
        case (cls_s)
          CLS_R:                    next_state_s = EXEC_R;
          CLS_I:                    next_state_s = EXEC_I;
          CLS_LD, CLS_ST:           next_state_s = ADDR;
          CLS_CBZ, CLS_CBNZ, CLS_B: next_state_s = BRANCH;
          default:                  next_state_s = FAULT;
        endcase
      end
      EXEC_R, EXEC_I: next_state_s = WB_ALU;
      ADDR: begin
        if (cls_s == CLS_LD)       next_state_s = MEM_RD;
        else if (cls_s == CLS_ST)  next_state_s = MEM_WR;
        else                       next_state_s = FAULT;
      end
      MEM_RD: begin
        if (bus.mem_ready)  next_state_s = WB_MEM;
        else if (wd_hit_s)  next_state_s = FAULT;
        else                next_state_s = MEM_RD;
      end
      MEM_WR: begin
        if (bus.mem_ready)  next_state_s = FETCH;
        else if (wd_hit_s)  next_state_s = FAULT;
        else                next_state_s = MEM_WR;
      end
      WB_ALU, WB_MEM, BRANCH: next_state_s = FETCH;
      FAULT:                  next_state_s = FAULT;
      default:                next_state_s = FAULT;
    endcase
  end

  // State, watchdog counter and registered Moore control word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= FETCH;
      wait_cnt_r <= {CNT_W{1'b0}};
      ctl_r      <= moore_ctrl(FETCH);
    end else begin
      state_r <= next_state_s;
      ctl_r   <= moore_ctrl(next_state_s);
      if (next_state_s != state_r) begin
        wait_cnt_r <= {CNT_W{1'b0}};
      end else if (waiting_s && (MAX_WAIT != 0)) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  // Outputs that depend on mem_ready, zero or opcode class in the current state.
  always_comb begin
    pc_write_s   = 1'b0;
    pc_src_s     = PC_SRC_SEQ;
    ir_write_s   = 1'b0;
    instr_done_s = ctl_r.instr_done;
    illegal_s    = 1'b0;
    case (state_r)
      FETCH: begin
        ir_write_s = bus.mem_ready;
        pc_write_s = bus.mem_ready;
      end
      DECODE: illegal_s    = (cls_s == CLS_ILL);
      MEM_WR: instr_done_s = bus.mem_ready;
      BRANCH: begin
        case (cls_s)
          CLS_B:    begin pc_write_s = 1'b1;      pc_src_s = PC_SRC_UNCOND; end
          CLS_CBZ:  begin pc_write_s = bus.zero;  pc_src_s = PC_SRC_COND;   end
          CLS_CBNZ: begin pc_write_s = !bus.zero; pc_src_s = PC_SRC_COND;   end
          default:  begin pc_write_s = 1'b0;      pc_src_s = PC_SRC_SEQ;    end
        endcase
      end
      default: pc_write_s = 1'b0;
    endcase
  end

  assign bus.pc_write      = !reset && pc_write_s;
  assign bus.pc_src        = reset ? 2'b00 : pc_src_s;
  assign bus.ir_write      = !reset && ir_write_s;
  assign bus.iord          = !reset && ctl_r.iord;
  assign bus.mem_read      = !reset && ctl_r.mem_read;
  assign bus.mem_write     = !reset && ctl_r.mem_write;
  assign bus.reg2loc       = !reset && r2l_s && (state_r != FETCH) && (state_r != FAULT);
  assign bus.alu_src_b     = reset ? 2'b00 : ctl_r.alu_src_b;
  assign bus.alu_op        = reset ? 2'b00 : ctl_r.alu_op;
  assign bus.mem_to_reg    = !reset && ctl_r.mem_to_reg;
  assign bus.reg_write     = !reset && ctl_r.reg_write;
  assign bus.instr_done    = !reset && instr_done_s;
  assign bus.illegal_instr = !reset && illegal_s;
  assign bus.fault         = !reset && ctl_r.fault;
  assign bus.state_o       = reset ? 4'd0 : state_r;

endmodule
